// File: rtl/down_counter.sv
// Loadable down-counter with IDLE/RUN/DONE sequencing, borrow-out and a one-cycle done pulse.
// Define DOWN_COUNTER_RELOAD_EN for auto-reload from the last loaded value on borrow.
module down_counter #(
    parameter int N = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [N-1:0] initld,
    input  logic         en,
    input  logic         start,
    output logic [N-1:0] count,
    output logic         busy,
    output logic         bo,
    output logic         done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] count_q, count_d;
    logic         done_q, done_d;
`ifdef DOWN_COUNTER_RELOAD_EN
    logic [N-1:0] reload_q, reload_d;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;
`ifdef DOWN_COUNTER_RELOAD_EN
        reload_d = reload_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (ld) begin
                    count_d = initld;
`ifdef DOWN_COUNTER_RELOAD_EN
                    reload_d = initld;
`endif
                end
                // start sees the freshly loaded value when ld arrives in the same cycle
                if (start) state_d = (count_d != '0) ? S_RUN : S_DONE;
            end
            S_RUN: begin
                if (ld) begin
                    count_d = initld;
`ifdef DOWN_COUNTER_RELOAD_EN
                    reload_d = initld;
`endif
                end else if (en) begin
                    if (count_q != '0) begin
                        count_d = count_q - 1'b1;
                    end else begin
`ifdef DOWN_COUNTER_RELOAD_EN
                        if (reload_q != '0) begin
                            count_d = reload_q;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_DONE;
                        end
`else
                        state_d = S_DONE;
`endif
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_DONE) done_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
`ifdef DOWN_COUNTER_RELOAD_EN
            reload_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
`ifdef DOWN_COUNTER_RELOAD_EN
            reload_q <= reload_d;
`endif
        end
    end

    assign count = count_q;
    assign busy  = (state_q == S_RUN);
    assign bo    = busy & en & (count_q == '0);
    assign done  = done_q;

endmodule

// File: doc/down_counter.md
DOWN_COUNTER -- requirements
Module: down_counter

Interface
REQ-001 The block SHALL provide parameter N, default 6, as the width of the count and load value.
REQ-002 The block SHALL provide port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL provide port rst, input, 1; reset is synchronous and active-high.
REQ-004 The block SHALL provide port ld, input, 1, loading initld into count and into the reload register.
REQ-005 The block SHALL provide port initld, input, N, the load value.
REQ-006 The block SHALL provide port en, input, 1, the decrement enable, honoured only in RUN.
REQ-007 The block SHALL provide port start, input, 1, the run request, honoured only in IDLE.
REQ-008 The block SHALL provide port count, output, N, the current counter value.
REQ-009 The block SHALL provide port busy, output, 1, high while the state is RUN.
REQ-010 The block SHALL provide port bo, output, 1, combinational borrow-out equal to busy & en & (count == 0).
REQ-011 The block SHALL provide port done, output, 1, a registered one-cycle completion pulse.

Function
REQ-012 The block SHALL implement three states: IDLE, RUN and DONE.
REQ-013 IDLE: ld=1 SHALL set count and the reload register to initld on the next edge.
REQ-014 IDLE: start=1 with count != 0 SHALL move to RUN; with count == 0 it SHALL move directly to DONE.
REQ-015 IDLE: ld and start asserted in the same cycle SHALL load, then evaluate start against the newly loaded value.
- The state SHALL be RUN if initld != 0, DONE otherwise.
REQ-016 RUN: en=1 with count != 0 SHALL decrement count by 1; en=0 SHALL hold count.
REQ-017 RUN: en=1 with count == 0 SHALL assert bo in that cycle, then move to DONE with count held at 0 (no wrap to 2^N-1).
REQ-018 RUN: ld=1 SHALL reload count and the reload register from initld, stay in RUN, and take priority over decrement.
- bo SHALL still reflect the pre-edge count.
REQ-019 DONE: done SHALL be 1 for exactly one cycle, then the state SHALL return to IDLE; done SHALL be 0 in every other state.
REQ-020 start SHALL be ignored in RUN and DONE; ld SHALL be ignored in DONE.
REQ-021 Latency: for a load value V != 0 with en held high, bo SHALL assert V+1 cycles after entry to RUN, and done SHALL follow 1 cycle later.

Reset
REQ-022 rst=1 SHALL, at the next edge, force state IDLE, count 0, reload register 0, done 0; busy and bo SHALL therefore be 0.
REQ-023 rst SHALL take priority over ld, start and en in every state, including mid-RUN and in DONE (the pending done pulse is cancelled).
REQ-024 No output SHALL depend on power-up values once one reset cycle has occurred.

Configuration
REQ-025 Macro DOWN_COUNTER_RELOAD_EN SHALL select auto-reload.
REQ-026 With DOWN_COUNTER_RELOAD_EN defined, RUN with en=1 and count == 0 SHALL assert bo, reload count from the reload register, and stay in RUN.
- done SHALL also pulse for one cycle while remaining in RUN.
- If the reload register is 0, the block SHALL instead move to DONE per REQ-017.
- Leaving RUN in this mode SHALL happen only via that zero-reload case or via rst.
REQ-027 Without DOWN_COUNTER_RELOAD_EN, behaviour SHALL be exactly REQ-017 and the reload register MAY be omitted.

Verification
REQ-028 Reset mid-RUN: ld initld=5, start, en=1 for 2 cycles, rst=1 -> next cycle count=0, busy=0, done=0, state IDLE.
REQ-029 Basic count: N=6, ld initld=3, start, en=1 continuous -> count 3,2,1,0 in RUN, bo=1 on the count=0 cycle, done=1 the next cycle, then busy=0.
REQ-030 Enable gating: initld=2, start, en toggled 1,0,1,0,1 -> count 2,1,1,0,0 with bo only on the final en=1 cycle at count 0.
REQ-031 Zero start and reload: ld initld=0 plus start -> DONE then one-cycle done, no bo; separately ld initld=7 during RUN at count=2 with en=1 -> count=7, stays busy.
REQ-032 Width boundary: initld=63 (N=6), en=1 -> 63 decrements, bo at count 0, never shows 63 after reaching 0; with DOWN_COUNTER_RELOAD_EN -> count returns to 63, done pulses, busy stays 1.
